mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the load/store unit (LSU).
- Grants one requester at a time with 2-way round-robin on contention.
- Latches the granted request's address, write-enable and write data, and holds the transaction until memory signals ready.
- Drives the select of the memory-side address/data 2:1 steering and returns read data with a done pulse; a watchdog aborts hung transactions.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- TIMEOUT, 255, max wait cycles for mem_ready before abort; valid range 1..65535.
- TO_W, 16, width of the watchdog counter; must satisfy TOUT ≤ 2^TO_W − 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  IF request; held high until if_done or if_err
- if_addr  in  ADDR_W  IF read address
- lsu_req  in  1  LSU request; held high until lsu_done or lsu_err
- lsu_we  in  1  LSU write enable (1 = store)
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  LSU store data
- if_gnt  out  1  one-cycle pulse: IF request accepted
- lsu_gnt  out  1  one-cycle pulse: LSU request accepted
- if_done  out  1  one-cycle pulse: IF transaction complete, rdata valid
- lsu_done  out  1  one-cycle pulse: LSU transaction complete
- if_err  out  1  one-cycle pulse: IF transaction timed out
- lsu_err  out  1  one-cycle pulse: LSU transaction timed out
- rdata  out  DATA_W  registered read data; valid in the done cycle, held afterwards
- sel  out  1  current owner: 0 = IF, 1 = LSU
- mem_req  out  1  memory request; high throughout SERVE
- mem_we  out  1  memory write enable (latched)
- mem_addr  out  ADDR_W  memory address (latched)
- mem_wdata  out  DATA_W  memory write data (latched)
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high; every flop clears immediately on rst.
- Reset values: state = IDLE; all pulses, mem_req, mem_we and sel = 0; mem_addr, mem_wdata and rdata = 0; last_owner = LSU, so IF wins the first tie.
- FSM state IDLE:
  - Neither request: stay in IDLE.
  - Only one request: grant that requester.
  - Both requests: grant the requester that is not last_owner.
  - On a grant, at the next edge:
    - owner, sel, mem_addr, mem_we and mem_wdata latch from the winner's inputs;
    - mem_we forced to 0 for IF;
    - the matching gnt pulses;
    - mem_req rises and the state moves to SERVE;
    - the watchdog clears.
- FSM state SERVE:
  - mem_req = 1; latched outputs stay stable; requester inputs are ignored.
  - Each cycle without mem_ready increments the watchdog.
  - If mem_ready: at the next edge, rdata <= mem_rdata, owner's done pulses, last_owner <= owner, mem_req = 0, state = IDLE.
  - If the watchdog reaches TIMEOUT without mem_ready: at the next edge, owner's err pulses, rdata is unchanged, last_owner <= owner, mem_req = 0, state = IDLE.
  - If mem_ready arrives in the same cycle the timeout would fire, mem_ready wins and done pulses, not err.
- Latency:
  - Request in IDLE at edge N → gnt and mem_req at N+1.
  - mem_ready sampled at edge M → done and rdata at M+1.
  - Earliest next grant: M+2, because IDLE lasts at least one cycle. Back-to-back contention therefore alternates owners.
- A request dropped mid-service does not abort the transaction; it still completes and done pulses.
- A request held after done is treated as a new request.
- Store completion: rdata is still loaded from mem_rdata (don't-care data); only lsu_done is meaningful.
- Reset mid-SERVE: transaction abandoned; no done or err pulse; memory side must tolerate mem_req dropping.
- sel changes only on a grant edge; it stays at the last owner while in IDLE.

Decomposition:
- Shared header (include-guarded): state encodings IDLE = 1'b0, SERVE = 1'b1; owner encodings OWN_IF = 0, OWN_LSU = 1.
- Sub-module rr_arb2 (combinational): inputs req0, req1, last; outputs pick, any.
- Address and write-data steering: ADDR_W and DATA_W instances of the team's gate-level mux2 cell, selected by the grant pick, feeding the latch registers.

Test Plan:
- Reset, then if_req = 1 with if_addr = 0x100; mem_ready the cycle after mem_req rises, with mem_rdata = 0xDEADBEEF → if_gnt at cycle 1, mem_addr = 0x100, if_done with rdata = 0xDEADBEEF one cycle after mem_ready.
- if_req and lsu_req both held continuously, mem_ready immediate → grants alternate IF, LSU, IF, LSU; the first grant goes to IF after reset.
- LSU store (lsu_we = 1, lsu_addr = 0x200, lsu_wdata = 0x12345678) with mem_ready delayed 5 cycles → mem_we = 1, mem_addr and mem_wdata stable for all 5 cycles, lsu_done pulses once.
- TIMEOUT = 4, mem_ready never asserted → lsu_err pulses 5 cycles after grant, rdata unchanged, then IF is granted next if requesting.
- mem_ready asserted on the exact timeout cycle → done pulses and err does not.
- rst asserted in SERVE → mem_req, gnt and done drop asynchronously; after release, if both request, IF is granted first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states and owner ids.
`ifndef MEM_PORT_ARBITER_PKG_SV
`define MEM_PORT_ARBITER_PKG_SV

package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

`endif

// File: rtl/mem_port_arbiter_mux2.sv
// Gate-level 2:1 mux cell; one instance per steered address/data bit.
module mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic s_i,
  output logic y_o
);

  assign y_o = (a_i & ~s_i) | (b_i & s_i);

endmodule

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not last.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic pick_o,
  output logic any_o
);

  always_comb begin
    any_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      pick_o = (last_i == OWN_IF) ? OWN_LSU : OWN_IF;
    end else if (req1_i) begin
      pick_o = OWN_LSU;
    end else begin
      pick_o = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, holding each
// granted transaction until mem_ready or until the watchdog aborts it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              if_gnt,
  output logic              lsu_gnt,
  output logic              if_done,
  output logic              lsu_done,
  output logic              if_err,
  output logic              lsu_err,
  output logic [DATA_W-1:0] rdata,
  output logic              sel,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [TO_W-1:0] TOUT = TO_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              if_gnt_q, if_gnt_d, lsu_gnt_q, lsu_gnt_d;
  logic              if_done_q, if_done_d, lsu_done_q, lsu_done_d;
  logic              if_err_q, if_err_d, lsu_err_q, lsu_err_d;

  logic              pick, any;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  rr_arb2 u_arb (
    .req0_i (if_req),
    .req1_i (lsu_req),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any)
  );

  for (genvar i = 0; i < ADDR_W; i++) begin : g_addr_mux
    mux2 u_mux (
      .a_i (if_addr[i]),
      .b_i (lsu_addr[i]),
      .s_i (pick),
      .y_o (addr_mux[i])
    );
  end

  // IF never writes, so its side of the data steering is tied low.
  for (genvar i = 0; i < DATA_W; i++) begin : g_wdata_mux
    mux2 u_mux (
      .a_i (1'b0),
      .b_i (lsu_wdata[i]),
      .s_i (pick),
      .y_o (wdata_mux[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_d        = wd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_gnt_d    = 1'b0;
    lsu_gnt_d   = 1'b0;
    if_done_d   = 1'b0;
    lsu_done_d  = 1'b0;
    if_err_d    = 1'b0;
    lsu_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = SERVE;
          owner_d     = pick;
          mem_req_d   = 1'b1;
          mem_we_d    = (pick == OWN_LSU) & lsu_we;
          mem_addr_d  = addr_mux;
          mem_wdata_d = wdata_mux;
          wd_d        = '0;
          if_gnt_d    = (pick == OWN_IF);
          lsu_gnt_d   = (pick == OWN_LSU);
        end
      end
      SERVE: begin
        // mem_ready takes priority over a watchdog expiring in the same cycle.
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          last_d     = owner_q;
          rdata_d    = mem_rdata;
          if_done_d  = (owner_q == OWN_IF);
          lsu_done_d = (owner_q == OWN_LSU);
        end else if (wd_q == TOUT) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          last_d    = owner_q;
          if_err_d  = (owner_q == OWN_IF);
          lsu_err_d = (owner_q == OWN_LSU);
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_LSU;
      wd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      lsu_gnt_q   <= 1'b0;
      if_done_q   <= 1'b0;
      lsu_done_q  <= 1'b0;
      if_err_q    <= 1'b0;
      lsu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_gnt_q    <= if_gnt_d;
      lsu_gnt_q   <= lsu_gnt_d;
      if_done_q   <= if_done_d;
      lsu_done_q  <= lsu_done_d;
      if_err_q    <= if_err_d;
      lsu_err_q   <= lsu_err_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign lsu_gnt   = lsu_gnt_q;
  assign if_done   = if_done_q;
  assign lsu_done  = lsu_done_q;
  assign if_err    = if_err_q;
  assign lsu_err   = lsu_err_q;
  assign rdata     = rdata_q;
  assign sel       = owner_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
